// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch handshake, issue/stall, redirect priority and halt.
// Define PC_SEQUENCER_ALIGN_CHECK_EN to trap misaligned jr targets to FAULT_VECTOR with a sticky fault flag.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] FAULT_VECTOR = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    input  logic        halt,
    output logic [31:0] pc,
    output logic        pc_we,
    output logic        fault
);

    // state  | meaning
    // IDLE   | one quiet cycle after reset release
    // FETCH  | imem_req high, waiting for imem_ack
    // ISSUE  | instruction presented to decode, redirects/halt sampled
    // HALTED | terminal until reset
    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALTED} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_imem_req;
    logic        r_instr_valid;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_target;
    logic [31:0] w_jump_target;
    logic [31:0] w_jr_target;
    logic [31:0] w_next_pc;
    logic        w_advance;

    assign w_pc_plus4      = r_pc + 32'd4;
    assign w_branch_target = w_pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
    assign w_jump_target   = {w_pc_plus4[31:28], jump_target, 2'b00};
    assign w_advance       = (r_state == ISSUE) && !stall && !halt;

`ifdef PC_SEQUENCER_ALIGN_CHECK_EN
    logic w_misalign;
    logic r_fault;

    assign w_misalign  = jr && (jr_addr[1:0] != 2'b00);
    assign w_jr_target = w_misalign ? FAULT_VECTOR : jr_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fault <= 1'b0;
        end else if (w_advance && w_misalign) begin
            r_fault <= 1'b1;
        end
    end

    assign fault = r_fault;
`else
    // Low address bits are dropped so a register-indirect jump always lands word-aligned.
    assign w_jr_target = jr_addr & 32'hFFFF_FFFC;
    assign fault       = 1'b0;
`endif

    always_comb begin
        w_next_pc = w_pc_plus4;
        if (jr) begin
            w_next_pc = w_jr_target;
        end else if (jump) begin
            w_next_pc = w_jump_target;
        end else if (branch_taken) begin
            w_next_pc = w_branch_target;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_pc          <= RESET_PC;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state    <= FETCH;
                    r_imem_req <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack) begin
                        r_state       <= ISSUE;
                        r_imem_req    <= 1'b0;
                        r_instr_valid <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (!stall) begin
                        r_instr_valid <= 1'b0;
                        if (halt) begin
                            r_state <= HALTED;
                        end else begin
                            r_state    <= FETCH;
                            r_imem_req <= 1'b1;
                            r_pc       <= w_next_pc;
                        end
                    end
                end
                HALTED: begin
                    r_state       <= HALTED;
                    r_imem_req    <= 1'b0;
                    r_instr_valid <= 1'b0;
                end
                default: begin
                    r_state       <= IDLE;
                    r_imem_req    <= 1'b0;
                    r_instr_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_pc;
    assign instr_valid = r_instr_valid;
    assign pc          = r_pc;
    assign pc_we       = w_advance;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter FAULT_VECTOR, default 32'h0000_0080, redirect target on alignment fault.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-006 SHALL have port imem_addr  output  32  fetch address; always equals pc.
REQ-007 SHALL have port imem_ack  input  1  memory returned the instruction at imem_addr.
REQ-008 SHALL have port instr_valid  output  1  fetched instruction is presented to decode.
REQ-009 SHALL have port stall  input  1  decode cannot consume the current instruction.
REQ-010 SHALL have port branch_taken  input  1  plus branch_offset  input  16  conditional branch with signed word offset.
REQ-011 SHALL have port jump  input  1  plus jump_target  input  26  J-type absolute jump.
REQ-012 SHALL have port jr  input  1  plus jr_addr  input  32  register-indirect jump.
REQ-013 SHALL have port halt  input  1  stop sequencing after the current instruction.
REQ-014 SHALL have ports pc  output  32  current PC, and pc_we  output  1  write-enable for the program counter register.
REQ-015 SHALL have port fault  output  1  sticky alignment-fault flag.

Function
REQ-016 SHALL implement states IDLE, FETCH, ISSUE, HALTED.
REQ-017 IDLE: all request/valid outputs 0; next cycle unconditionally FETCH.
REQ-018 FETCH: imem_req=1, imem_addr=pc; on imem_ack=1 go to ISSUE next cycle; otherwise hold indefinitely.
REQ-019 ISSUE: instr_valid=1 (registered, first asserted one cycle after the ack edge); with stall=1 hold state, pc and pc_we=0.
REQ-020 ISSUE with stall=0 and halt=0: pc_we=1 that cycle, pc loads next_pc at the edge, state returns to FETCH.
REQ-021 ISSUE with stall=0 and halt=1: pc_we=0, pc unchanged, go to HALTED; HALTED is terminal until reset, all request/valid outputs 0.
REQ-022 next_pc priority when several are asserted: jr > jump > branch_taken > sequential.
REQ-023 pc_plus4 = pc + 4 modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-024 branch target = pc_plus4 + {sign-extended branch_offset, 2'b00}, modulo 2^32.
REQ-025 jump target = {pc_plus4[31:28], jump_target, 2'b00}.
REQ-026 jr target = jr_addr, subject to REQ-033/034.
REQ-027 Redirect inputs, halt, and imem_ack outside their sampling state (ISSUE for redirects/halt, FETCH for ack) SHALL be ignored.
REQ-028 Throughput: minimum 2 cycles per instruction (FETCH with same-cycle ack, then ISSUE).

Reset
REQ-029 Asserting reset SHALL immediately (asynchronously) force state IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, pc_we=0, fault=0.
REQ-030 Reset during an outstanding fetch SHALL abandon it; a late imem_ack after reset is ignored.
REQ-031 First fetch after reset deassertion SHALL be at RESET_PC, two edges after release (IDLE then FETCH).

Configuration
REQ-032 Macro PC_SEQUENCER_ALIGN_CHECK_EN selects jr alignment checking.
REQ-033 Defined: ISSUE with stall=0, jr=1, jr_addr[1:0]!=0 SHALL load pc=FAULT_VECTOR, set fault=1 (sticky until reset), pc_we=1, go to FETCH; if halt=1 in the same cycle, halt SHALL take precedence.
REQ-034 Not defined: jr target SHALL be {jr_addr[31:2], 2'b00}; fault SHALL be constant 0.

Verification
REQ-035 Reset release, imem_ack held 1, no redirects -> fetch addresses 0,4,8,12 on successive FETCH cycles; pc_we pulses every 2nd cycle.
REQ-036 pc=0x100, branch_taken=1, branch_offset=16'hFFFF -> next fetch at 0x100; jump=1 and branch_taken=1 together with jump_target=26'h40 -> next fetch at 0x100.
REQ-037 pc=0xFFFF_FFFC sequential -> next pc 0x0; stall=1 for 3 cycles in ISSUE -> instr_valid held 3 extra cycles, pc unchanged, pc_we=0.
REQ-038 imem_ack withheld 5 cycles -> imem_req stays 1, imem_addr stable; reset asserted mid-FETCH -> imem_req drops same cycle, pc=RESET_PC.
REQ-039 jr=1, jr_addr=0x203: macro defined -> pc=0x80, fault=1; macro undefined -> pc=0x200, fault=0.
REQ-040 halt=1 in ISSUE with stall=0 -> HALTED, no further imem_req, pc frozen until reset.
